// File: rtl/jtag_debug_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_debug_ocimem_ctrl
//
// Debug-side on-chip memory controller that sits after the JTAG debug module.
// It owns a small debug RAM (2**ADDR_W x 32-bit words) and the monitor
// handshake flags. JTAG commands arrive as one-cycle sysclk strobes with jdo.
// The CPU reaches the same RAM and flags through a waitrequest-style slave port.
//
// Optional feature (compile-time macro): OCIMEM_PARITY_EN
//   When defined, the RAM is 33 bits wide and stores even parity on every write.
//   A parity mismatch on any read sets monitor_error. Read data is still the
//   raw 32-bit word.
//
// Ports
//   clk, reset_n             system clock; synchronous active-low reset
//   jdo[37:0]                JTAG command/data, valid together with the strobes
//   take_action_ocimem_a     address/control command strobe
//   take_action_ocimem_b     data write/read command strobe
//   take_no_action_ocimem_a  MonDReg refresh strobe (no address increment)
//   MonDReg[31:0]            monitor data register, shifted out by JTAG
//   monitor_ready/error/go   monitor handshake flags
//   jtag_overrun             sticky; set when a strobe is dropped because busy
//   cpu_address[ADDR_W:0]    top bit selects register space, else RAM word
//   cpu_read, cpu_write      CPU requests, held until waitrequest drops
//   cpu_writedata[31:0]      CPU write data
//   cpu_readdata[31:0]       CPU read data, valid in the cycle waitrequest is low
//   cpu_waitrequest          CPU stall
// -----------------------------------------------------------------------------
module jtag_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go,
    output logic              jtag_overrun,
    input  logic [ADDR_W:0]   cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

`ifdef OCIMEM_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_JACC = 2'd1,
        S_CACC = 2'd2
    } state_t;

    // Builds the stored RAM word; with parity enabled the top bit makes the
    // XOR of all stored bits zero.
    function automatic logic [RAM_W-1:0] pack_word(input logic [31:0] d);
`ifdef OCIMEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mon_a_q, mon_a_d;
    logic [31:0]        mon_d_q, mon_d_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               go_q, go_d;
    logic               ovr_q, ovr_d;
    // One-cycle markers for work that completes in the cycle after acceptance.
    logic               jcap_q, jcap_d;      // MonDReg <= RAM read data
    logic               jinc_q, jinc_d;      // MonAReg increment after ocimem_b
    logic               crd_q, crd_d;        // CPU RAM read data is on ram_q
    logic               creg_q, creg_d;      // CPU register read in flight
    logic [2:0]         creg_data_q, creg_data_d;
    logic               rchk_q, rchk_d;      // ram_q holds a fresh read to check
    logic [31:0]        rd_hold_q, rd_hold_d;

    logic               ram_we, ram_re;
    logic [ADDR_W-1:0]  ram_addr;
    logic [RAM_W-1:0]   ram_wdata;
    logic [RAM_W-1:0]   ram_q;
    logic [RAM_W-1:0]   mem [0:(1<<ADDR_W)-1];

    logic               strobe_any, cpu_req, jtag_accept, cpu_accept;
    logic               cpu_is_reg, cpu_reg0;
    logic [31:0]        cpu_rdata;
    logic               unused_jdo;

    assign strobe_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign cpu_req     = cpu_read | cpu_write;
    assign jtag_accept = (state_q == S_IDLE) && strobe_any;
    assign cpu_is_reg  = cpu_address[ADDR_W];
    assign cpu_reg0    = (cpu_address[ADDR_W-1:0] == '0);
    assign unused_jdo  = ^{jdo[37:36], jdo[1:0]};

    // crd_q/creg_q are only high in the CACC cycle, so outside it the last
    // presented value is held.
    assign cpu_rdata = crd_q  ? ram_q[31:0] :
                       creg_q ? {29'b0, creg_data_q} : rd_hold_q;

    always_comb begin
        state_d     = state_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        ready_d     = ready_q;
        error_d     = error_q;
        go_d        = go_q;
        ovr_d       = ovr_q;
        jcap_d      = 1'b0;
        jinc_d      = 1'b0;
        crd_d       = 1'b0;
        creg_d      = 1'b0;
        creg_data_d = 3'b000;
        rchk_d      = 1'b0;
        rd_hold_d   = cpu_rdata;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = mon_a_q;
        ram_wdata   = pack_word(jdo[34:3]);
        cpu_accept  = 1'b0;

        // Second half of a JTAG command accepted last cycle.
        if (jcap_q) mon_d_d = ram_q[31:0];
        if (jinc_q) mon_a_d = mon_a_q + 1'b1;

`ifdef OCIMEM_PARITY_EN
        if (rchk_q && (^ram_q)) error_d = 1'b1;
`endif

        // Any strobe that finds the FSM busy is lost.
        if (strobe_any && (state_q != S_IDLE)) ovr_d = 1'b1;

        // JACC only waits for the capture register; the RAM port is already
        // free there, so a stalled CPU request is taken in that cycle.
        case (state_q)
            S_IDLE: begin
                if (strobe_any) begin
                    state_d = S_JACC;
                end else if (cpu_req) begin
                    state_d    = S_CACC;
                    cpu_accept = 1'b1;
                end
            end
            S_JACC: begin
                if (cpu_req) begin
                    state_d    = S_CACC;
                    cpu_accept = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CACC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (jtag_accept) begin
            if (take_action_ocimem_b) begin
                jinc_d = 1'b1;
                if (jdo[35]) begin
                    ram_we  = 1'b1;
                    mon_d_d = jdo[34:3];
                end else begin
                    ram_re = 1'b1;
                    jcap_d = 1'b1;
                    rchk_d = 1'b1;
                end
            end else if (take_action_ocimem_a) begin
                mon_a_d  = jdo[ADDR_W+1:2];
                ram_addr = jdo[ADDR_W+1:2];
                if (jdo[33]) go_d = 1'b1;
                if (jdo[35]) begin
                    ram_re = 1'b1;
                    jcap_d = 1'b1;
                    rchk_d = 1'b1;
                end
            end else begin
                ram_re = 1'b1;
                jcap_d = 1'b1;
                rchk_d = 1'b1;
            end
        end

        if (cpu_accept) begin
            ram_addr = cpu_address[ADDR_W-1:0];
            if (cpu_is_reg) begin
                if (cpu_read) begin
                    creg_d      = 1'b1;
                    creg_data_d = cpu_reg0 ? {go_q, error_q, ready_q} : 3'b000;
                end
                if (cpu_write && cpu_reg0) begin
                    if (cpu_writedata[0]) ready_d = 1'b1;
                    if (cpu_writedata[1]) error_d = 1'b1;
                    if (cpu_writedata[2]) go_d    = 1'b0;
                end
            end else begin
                if (cpu_write) begin
                    ram_we    = 1'b1;
                    ram_wdata = pack_word(cpu_writedata);
                end
                if (cpu_read) begin
                    ram_re = 1'b1;
                    crd_d  = 1'b1;
                    rchk_d = 1'b1;
                end
            end
        end

        // JTAG clear is applied last so it overrides any set in the same cycle.
        if (jtag_accept && take_action_ocimem_a && !take_action_ocimem_b && jdo[34]) begin
            ready_d = 1'b0;
            error_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            go_q        <= 1'b0;
            ovr_q       <= 1'b0;
            jcap_q      <= 1'b0;
            jinc_q      <= 1'b0;
            crd_q       <= 1'b0;
            creg_q      <= 1'b0;
            creg_data_q <= 3'b000;
            rchk_q      <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            go_q        <= go_d;
            ovr_q       <= ovr_d;
            jcap_q      <= jcap_d;
            jinc_q      <= jinc_d;
            crd_q       <= crd_d;
            creg_q      <= creg_d;
            creg_data_q <= creg_data_d;
            rchk_q      <= rchk_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    // Debug RAM: single port, synchronous read, contents not reset.
    // Writes are blocked while reset_n is low.
    always_ff @(posedge clk) begin
        if (reset_n && ram_we) mem[ram_addr] <= ram_wdata;
        if (reset_n && ram_re) ram_q <= mem[ram_addr];
    end

    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;
    assign monitor_go      = go_q;
    assign jtag_overrun    = ovr_q;
    assign cpu_readdata    = cpu_rdata;
    assign cpu_waitrequest = !reset_n || (cpu_req && (state_q != S_CACC));

endmodule

// File: tb/tb_jtag_debug_ocimem_ctrl.sv
module tb_jtag_debug_ocimem_ctrl;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tna = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go, jtag_overrun;
  logic [8:0]  cpu_address = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;

  jtag_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .monitor_go(monitor_go), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // kind: 0 MonDReg, 1 flags {overrun,go,error,ready}, 2 waitrequest, 3 cpu_readdata
  typedef struct { int due; int kind; logic [31:0] exp; } jexp_t;
  typedef struct { logic is_rd; logic [31:0] exp; int waits; } cexp_t;
  jexp_t jq[$];
  cexp_t cq[$];

  function automatic string kname(int k);
    case (k)
      0: return "MonDReg";
      1: return "flags";
      2: return "waitrequest";
      default: return "cpu_readdata";
    endcase
  endfunction

  // Monitor: compares scheduled JTAG-side expectations and completed CPU accesses.
  int wcnt = 0;
  always @(negedge clk) begin
    logic [31:0] act;
    cexp_t e;
    for (int i = jq.size() - 1; i >= 0; i--) begin
      if (jq[i].due <= cyc) begin
        case (jq[i].kind)
          0: act = MonDReg;
          1: act = {28'b0, jtag_overrun, monitor_go, monitor_error, monitor_ready};
          2: act = {31'b0, cpu_waitrequest};
          default: act = cpu_readdata;
        endcase
        checks++;
        if (jq[i].due < cyc) begin
          failures++;
          $display("FAIL %s missed cycle %0d", kname(jq[i].kind), jq[i].due);
        end else if (act !== jq[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", kname(jq[i].kind), cyc, act, jq[i].exp);
        end
        jq.delete(i);
      end
    end
    if (reset_n && (cpu_read || cpu_write)) begin
      if (cpu_waitrequest) begin
        wcnt++;
      end else begin
        if (cq.size() == 0) begin
          checks++; failures++;
          $display("FAIL cpu_unexpected_completion cyc=%0d", cyc);
        end else begin
          e = cq.pop_front();
          checks++;
          if (wcnt != e.waits) begin
            failures++;
            $display("FAIL cpu_wait_cycles got=%0d expected=%0d", wcnt, e.waits);
          end
          if (e.is_rd) begin
            checks++;
            if (cpu_readdata !== e.exp) begin
              failures++;
              $display("FAIL cpu_readdata got=%h expected=%h", cpu_readdata, e.exp);
            end
          end
        end
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_j(input int dly, input int kind, input logic [31:0] v);
    jq.push_back('{cyc + dly, kind, v});
  endtask

  function automatic logic [37:0] jd(input logic b35, input logic b34, input logic b33,
                                     input logic [7:0] addr);
    return {2'b00, b35, b34, b33, 23'b0, addr, 2'b00};
  endfunction

  function automatic logic [37:0] jdat(input logic [31:0] d);
    return {2'b00, 1'b1, d, 3'b000};
  endfunction

  // kind 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a; md<0 skips the MonDReg check.
  task automatic jop(input int kind, input logic [37:0] j, input int md, input logic [31:0] mexp);
    tick();
    jdo = j; ta_a = (kind == 0); ta_b = (kind == 1); tna = (kind == 2);
    if (md >= 0) expect_j(md, 0, mexp);
    tick();
    ta_a = 1'b0; ta_b = 1'b0; tna = 1'b0;
    tick();
  endtask

  task automatic cpu(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp, input int waits);
    int n;
    cq.push_back('{!wr, exp, waits});
    tick();
    cpu_address = addr; cpu_write = wr; cpu_read = !wr; cpu_writedata = wd;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (cpu_waitrequest && n < 20);
    if (cpu_waitrequest) begin
      checks++; failures++;
      $display("FAIL cpu_timeout addr=%h", addr);
    end
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    expect_j(0, 2, 32'h1);
    tick();
    reset_n = 1'b1;
    expect_j(0, 0, 32'h0);
    expect_j(0, 1, 32'h0);
    expect_j(0, 3, 32'h0);
    jop(0, jd(0, 0, 0, 8'h00), 2, 32'h0);
    expect_j(0, 1, 32'h0);

    // Write burst from 0x10; third word lands at 0x12 if MonAReg advanced.
    jop(0, jd(0, 0, 0, 8'h10), -1, 32'h0);
    jop(1, jdat(32'hDEADBEEF), 1, 32'hDEADBEEF);
    jop(1, jdat(32'h12345678), 1, 32'h12345678);
    jop(1, jdat(32'hCAFEF00D), 1, 32'hCAFEF00D);

    // Readback
    jop(0, jd(1, 0, 0, 8'h10), 2, 32'hDEADBEEF);
    jop(1, jd(0, 0, 0, 8'h00), 2, 32'hDEADBEEF);
    jop(1, jd(0, 0, 0, 8'h00), 2, 32'h12345678);
    jop(0, jd(1, 0, 0, 8'h12), 2, 32'hCAFEF00D);

    // Contention: CPU read of 0x10 alongside an ocimem_b read of MonAReg=0x12
    fork
      jop(1, jd(0, 0, 0, 8'h00), 2, 32'hCAFEF00D);
      cpu(1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 2);
    join

    // CPU RAM write, CPU readback, JTAG readback of the same word
    cpu(1'b1, 9'h020, 32'h0BADF00D, 32'h0, 1);
    cpu(1'b0, 9'h020, 32'h0, 32'h0BADF00D, 1);
    jop(0, jd(1, 0, 0, 8'h20), 2, 32'h0BADF00D);

    // Wrap 0xFF -> 0x00
    jop(0, jd(0, 0, 0, 8'hFF), -1, 32'h0);
    jop(1, jdat(32'hAAAA5555), 1, 32'hAAAA5555);
    jop(1, jdat(32'h5555AAAA), 1, 32'h5555AAAA);
    jop(0, jd(1, 0, 0, 8'h00), 2, 32'h5555AAAA);
    jop(0, jd(1, 0, 0, 8'hFF), 2, 32'hAAAA5555);

    // Overrun: MonAReg=0xFF, write, then no_action strobe in the busy cycle
    tick();
    jdo = jdat(32'h11112222); ta_b = 1'b1;
    expect_j(1, 0, 32'h11112222);
    tick();
    ta_b = 1'b0; tna = 1'b1;
    expect_j(1, 1, 32'h8);
    expect_j(2, 0, 32'h11112222);
    tick();
    tna = 1'b0;
    tick();
    jop(1, jd(0, 0, 0, 8'h00), 2, 32'h5555AAAA);

    // Flags
    cpu(1'b1, 9'h100, 32'h3, 32'h0, 1);
    cpu(1'b0, 9'h100, 32'h0, 32'h3, 1);
    jop(0, jd(0, 0, 1, 8'h00), -1, 32'h0);
    expect_j(0, 1, 32'hF);
    cpu(1'b0, 9'h100, 32'h0, 32'h7, 1);
    cpu(1'b1, 9'h101, 32'h7, 32'h0, 1);
    cpu(1'b0, 9'h101, 32'h0, 32'h0, 1);
    cpu(1'b1, 9'h100, 32'h4, 32'h0, 1);
    cpu(1'b0, 9'h100, 32'h0, 32'h3, 1);
    jop(0, jd(0, 1, 0, 8'h00), -1, 32'h0);
    expect_j(0, 1, 32'h0);
    jop(0, jd(0, 1, 1, 8'h00), -1, 32'h0);
    expect_j(0, 1, 32'h4);

`ifdef OCIMEM_PARITY_EN
    dut.mem[8'h10] = dut.mem[8'h10] ^ 33'h1;
    jop(0, jd(1, 0, 0, 8'h10), 2, 32'hDEADBEEE);
    expect_j(0, 1, 32'h6);
`endif

    // Drain outstanding expectations
    for (int i = 0; i < 20 && (jq.size() > 0 || cq.size() > 0); i++) tick();
    while (jq.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s never checked", kname(jq[0].kind));
      void'(jq.pop_front());
    end
    while (cq.size() > 0) begin
      checks++; failures++;
      $display("FAIL cpu_access never completed");
      void'(cq.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
